mem_moc_responder: RTL and testbench



---
 rtl/mem_moc_responder_pkg.sv | 19 +
 rtl/mem_moc_responder_if.sv | 26 ++
 rtl/mem_moc_responder_byte_array.sv | 37 +++
 rtl/mem_moc_responder.sv | 162 ++++++++++++++++
 tb/tb_mem_moc_responder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_moc_responder_pkg.sv
// mem_pkg: shared definitions for the MFA/MOC memory responder.
//   state_t              - responder FSM encoding (IDLE / WAIT / DONE)
//   SZ_BYTE/SZ_HALF/SZ_WORD - DataSize codes (2'b11 is reserved and handled as a word)
//   WAIT_STATES_DEFAULT  - default number of wait states between acceptance and access
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WAIT_STATES_DEFAULT = 2;

endpackage

// File: rtl/mem_moc_responder_if.sv
// mem_moc_if: control-unit <-> memory handshake bundle.
//   MFA, RW, DataSize, Address, DataIn : driven by the control unit (master)
//   DataOut, MOC, Busy, Fault          : driven by the memory responder (slave)
interface mem_moc_if #(
  parameter int ADDR_W = 8
) ();
  logic              MFA;
  logic              RW;
  logic [1:0]        DataSize;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MOC;
  logic              Busy;
  logic              Fault;

  modport master (
    output MFA, RW, DataSize, Address, DataIn,
    input  DataOut, MOC, Busy, Fault
  );

  modport slave (
    input  MFA, RW, DataSize, Address, DataIn,
    output DataOut, MOC, Busy, Fault
  );
endinterface

// File: rtl/mem_moc_responder_byte_array.sv
// mem_byte_array: byte-wide storage of 2**ADDR_W bytes with a 4-lane port.
//   Clk   : clock, writes on posedge
//   base  : word-aligned base address of the 4-byte window
//   we    : per-lane write enables, we[3] = lane 0 = lowest address
//   wdata : write data, lane 0 in bits [31:24] (big-endian)
//   rdata : combinational big-endian read of the 4-byte window
// Lane addresses are computed modulo 2**ADDR_W. The contents have no reset.
module mem_byte_array #(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic [ADDR_W-1:0] base,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0]        mem_reg   [0:(2**ADDR_W)-1];
  logic [ADDR_W-1:0] lane_addr [4];

  // Lane gi holds byte base+gi; the sum truncates to ADDR_W bits, giving the wrap.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_addr[gi]            = base + ADDR_W'(gi);
      assign rdata[31-8*gi -: 8]      = mem_reg[lane_addr[gi]];
    end
  endgenerate

  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[3-i]) begin
        mem_reg[lane_addr[i]] <= wdata[31-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/mem_moc_responder.sv
// mem_moc_responder: memory-side responder for the MFA/MOC handshake.
//   Clk   : clock, all state updates on posedge
//   reset : synchronous, active-high
//   bus   : mem_moc_if.slave (MFA, RW, DataSize, Address, DataIn in;
//           DataOut, MOC, Busy, Fault out)
// A request is latched when MFA is seen in IDLE, the access happens after
// WAIT_STATES further edges, then MOC is held until MFA drops.
// Build option MEM_MISALIGN_FAULT_EN: misaligned halfword/word accesses raise
// Fault instead of being aligned down; otherwise Fault stays 0.
module mem_moc_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = WAIT_STATES_DEFAULT,
  parameter int CNT_W       = 4
) (
  input  logic     Clk,
  input  logic     reset,
  mem_moc_if.slave bus
);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg,   cnt_next;
  logic [ADDR_W-1:0] addr_reg,  addr_next;
  logic              rw_reg,    rw_next;
  logic [1:0]        size_reg,  size_next;
  logic [31:0]       din_reg,   din_next;
  logic              moc_reg,   moc_next;
  logic [31:0]       dout_reg,  dout_next;
  logic              fault_reg, fault_next;

  logic [ADDR_W-1:0] base;
  logic [3:0]        lane_we;
  logic [31:0]       lane_wdata;
  logic [31:0]       rdata;
  logic [31:0]       rd_value;
  logic [3:0]        mem_we;
  logic              access;
  logic              fault_hit;
  logic [1:0]        lane_inv;

  // Every access works on the enclosing aligned word; size only picks lanes.
  assign base     = {addr_reg[ADDR_W-1:2], 2'b00};
  assign lane_inv = ~addr_reg[1:0];

  always_comb begin
    lane_we    = 4'b1111;
    lane_wdata = din_reg;
    rd_value   = rdata;
    case (size_reg)
      SZ_BYTE: begin
        lane_we    = 4'b1000 >> addr_reg[1:0];
        lane_wdata = {4{din_reg[7:0]}};
        rd_value   = {24'd0, rdata[{lane_inv, 3'b000} +: 8]};
      end
      SZ_HALF: begin
        // Address[0] is ignored: the halfword sits in the upper or lower half.
        lane_we    = addr_reg[1] ? 4'b0011 : 4'b1100;
        lane_wdata = {2{din_reg[15:0]}};
        rd_value   = {16'd0, rdata[{~addr_reg[1], 4'b0000} +: 16]};
      end
      default: ;  // word and reserved code: full word
    endcase
  end

`ifdef MEM_MISALIGN_FAULT_EN
  assign fault_hit = ((size_reg == SZ_HALF) && addr_reg[0]) ||
                     (size_reg[1] && (addr_reg[1:0] != 2'b00));
`else
  assign fault_hit = 1'b0;
`endif

  assign access = (state_reg == WAIT) && bus.MFA && (cnt_reg == '0);
  // Reset on the access edge suppresses the write.
  assign mem_we = (access && !rw_reg && !fault_hit && !reset) ? lane_we : 4'b0000;

  mem_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .Clk   (Clk),
    .base  (base),
    .we    (mem_we),
    .wdata (lane_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      rw_reg    <= 1'b0;
      size_reg  <= SZ_BYTE;
      din_reg   <= '0;
      moc_reg   <= 1'b0;
      dout_reg  <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      rw_reg    <= rw_next;
      size_reg  <= size_next;
      din_reg   <= din_next;
      moc_reg   <= moc_next;
      dout_reg  <= dout_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    rw_next    = rw_reg;
    size_next  = size_reg;
    din_next   = din_reg;
    moc_next   = moc_reg;
    dout_next  = dout_reg;
    fault_next = fault_reg;
    case (state_reg)
      IDLE: begin
        if (bus.MFA) begin
          addr_next  = bus.Address;
          rw_next    = bus.RW;
          size_next  = bus.DataSize;
          din_next   = bus.DataIn;
          cnt_next   = CNT_W'(WAIT_STATES);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!bus.MFA) begin
          state_next = IDLE;  // abort: nothing written, DataOut kept
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          moc_next   = 1'b1;
          state_next = DONE;
          if (fault_hit) begin
            fault_next = 1'b1;
            dout_next  = '0;
          end else if (rw_reg) begin
            dout_next = rd_value;
          end
        end
      end
      DONE: begin
        if (!bus.MFA) begin
          moc_next   = 1'b0;
          fault_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.DataOut = dout_reg;
  assign bus.MOC     = moc_reg;
  assign bus.Busy    = (state_reg != IDLE);
  assign bus.Fault   = fault_reg;

endmodule

// File: tb/tb_mem_moc_responder.sv
// Directed testbench for mem_moc_responder (ADDR_W = 8, WAIT_STATES = 2).
module tb_mem_moc_responder;
  import mem_pkg::*;

  logic Clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_moc_if #(.ADDR_W(8)) bus ();

  mem_moc_responder #(.ADDR_W(8), .WAIT_STATES(2), .CNT_W(4)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Raise MFA with the given request and wait (bounded) for MOC.
  // Called just after a posedge; lat = edges after the sampling edge.
  task automatic txn(input logic rw, input logic [1:0] sz, input logic [7:0] addr,
                     input logic [31:0] din, output logic [31:0] dout,
                     output int lat, output bit tmo);
    bus.RW = rw; bus.DataSize = sz; bus.Address = addr; bus.DataIn = din;
    bus.MFA = 1'b1;
    lat = -1; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (bus.MOC === 1'b1) begin
        lat = i; tmo = 1'b0;
        break;
      end
    end
    dout = bus.DataOut;
    $display("txn rw=%0d size=%0d addr=%02h din=%08h -> dout=%08h lat=%0d fault=%0b tmo=%0b",
             rw, sz, addr, din, dout, lat, bus.Fault, tmo);
  endtask

  task automatic release_mfa();
    bus.MFA = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.MOC !== 1'b0) begin n_bad++; $display("FAIL reset_moc: got %0b want 0", bus.MOC); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", bus.Busy); end
    n_cmp++; if (bus.Fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %0b want 0", bus.Fault); end
    n_cmp++; if (bus.DataOut !== 32'h0) begin n_bad++; $display("FAIL reset_dout: got %08h want 00000000", bus.DataOut); end
  endtask

  task automatic test_word_rw();
    logic [31:0] d; int lat; bit tmo;
    txn(1'b0, SZ_WORD, 8'h10, 32'hDEADBEEF, d, lat, tmo);
    n_cmp++; if (tmo || lat != 3) begin n_bad++; $display("FAIL word_wr_latency: got %0d want 3", lat); end
    n_cmp++; if (bus.Busy !== 1'b1) begin n_bad++; $display("FAIL word_wr_busy: got %0b want 1", bus.Busy); end
    release_mfa();
    n_cmp++; if (bus.MOC !== 1'b0) begin n_bad++; $display("FAIL word_wr_moc_drop: got %0b want 0", bus.MOC); end
    txn(1'b1, SZ_WORD, 8'h10, 32'h0, d, lat, tmo);
    n_cmp++; if (tmo || lat != 3) begin n_bad++; $display("FAIL word_rd_latency: got %0d want 3", lat); end
    n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_rd_data: got %08h want deadbeef", d); end
    release_mfa();
  endtask

  task automatic test_strb();
    logic [31:0] d; int lat; bit tmo;
    txn(1'b0, SZ_WORD, 8'h20, 32'h11223344, d, lat, tmo); release_mfa();
    txn(1'b0, SZ_BYTE, 8'h23, 32'h000000A5, d, lat, tmo); release_mfa();
    txn(1'b1, SZ_WORD, 8'h20, 32'h0, d, lat, tmo); release_mfa();
    n_cmp++; if (tmo || d !== 32'h112233A5) begin n_bad++; $display("FAIL strb_word: got %08h want 112233a5", d); end
    txn(1'b1, SZ_BYTE, 8'h21, 32'h0, d, lat, tmo); release_mfa();
    n_cmp++; if (tmo || d !== 32'h00000022) begin n_bad++; $display("FAIL strb_byte: got %08h want 00000022", d); end
    txn(1'b1, SZ_HALF, 8'h22, 32'h0, d, lat, tmo); release_mfa();
    n_cmp++; if (tmo || d !== 32'h000033A5) begin n_bad++; $display("FAIL strb_half: got %08h want 000033a5", d); end
    txn(1'b1, 2'b11, 8'h20, 32'h0, d, lat, tmo); release_mfa();
    n_cmp++; if (tmo || d !== 32'h112233A5) begin n_bad++; $display("FAIL strb_reserved: got %08h want 112233a5", d); end
  endtask

  task automatic test_hold();
    logic [31:0] d; int lat; bit tmo;
    txn(1'b1, SZ_WORD, 8'h10, 32'h0, d, lat, tmo);
    for (int i = 0; i < 5; i++) begin
      bus.Address = 8'h20; bus.RW = 1'b0;  // must be ignored while in DONE
      @(posedge Clk); #1;
      n_cmp++; if (bus.MOC !== 1'b1) begin n_bad++; $display("FAIL hold_moc[%0d]: got %0b want 1", i, bus.MOC); end
      n_cmp++; if (bus.DataOut !== 32'hDEADBEEF) begin n_bad++; $display("FAIL hold_dout[%0d]: got %08h want deadbeef", i, bus.DataOut); end
    end
    release_mfa();
    n_cmp++; if (bus.MOC !== 1'b0) begin n_bad++; $display("FAIL hold_release_moc: got %0b want 0", bus.MOC); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL hold_release_busy: got %0b want 0", bus.Busy); end
  endtask

  task automatic test_abort();
    logic [31:0] d; int lat; bit tmo; bit saw_moc;
    txn(1'b0, SZ_BYTE, 8'h30, 32'h0000005A, d, lat, tmo); release_mfa();
    bus.RW = 1'b0; bus.DataSize = SZ_BYTE; bus.Address = 8'h30; bus.DataIn = 32'hFF;
    bus.MFA = 1'b1;
    @(posedge Clk); #1;
    n_cmp++; if (bus.Busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy: got %0b want 1", bus.Busy); end
    @(posedge Clk); #1;
    bus.MFA = 1'b0;
    saw_moc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      if (bus.MOC === 1'b1) saw_moc = 1'b1;
    end
    $display("txn abort write addr=30 din=ff moc_seen=%0b", saw_moc);
    n_cmp++; if (saw_moc !== 1'b0) begin n_bad++; $display("FAIL abort_moc: got %0b want 0", saw_moc); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got %0b want 0", bus.Busy); end
    n_cmp++; if (bus.DataOut !== 32'hDEADBEEF) begin n_bad++; $display("FAIL abort_dout: got %08h want deadbeef", bus.DataOut); end
    txn(1'b1, SZ_BYTE, 8'h30, 32'h0, d, lat, tmo); release_mfa();
    n_cmp++; if (tmo || d !== 32'h0000005A) begin n_bad++; $display("FAIL abort_mem: got %08h want 0000005a", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; int lat; bit tmo;
    txn(1'b0, SZ_HALF, 8'h40, 32'h00007788, d, lat, tmo); release_mfa();
    txn(1'b1, SZ_WORD, 8'h10, 32'h0, d, lat, tmo); release_mfa();
    bus.RW = 1'b0; bus.DataSize = SZ_BYTE; bus.Address = 8'h40; bus.DataIn = 32'h99;
    bus.MFA = 1'b1;
    repeat (3) begin @(posedge Clk); #1; end  // accept + two wait edges
    reset = 1'b1;                             // coincides with the access edge
    @(posedge Clk); #1;
    $display("txn reset during write addr=40 din=99");
    n_cmp++; if (bus.MOC !== 1'b0) begin n_bad++; $display("FAIL rstmid_moc: got %0b want 0", bus.MOC); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %0b want 0", bus.Busy); end
    n_cmp++; if (bus.DataOut !== 32'h0) begin n_bad++; $display("FAIL rstmid_dout: got %08h want 00000000", bus.DataOut); end
    reset = 1'b0; bus.MFA = 1'b0;
    @(posedge Clk); #1;
    txn(1'b1, SZ_HALF, 8'h40, 32'h0, d, lat, tmo); release_mfa();
    n_cmp++; if (tmo || d !== 32'h00007788) begin n_bad++; $display("FAIL rstmid_mem: got %08h want 00007788", d); end
  endtask

  task automatic test_misalign();
    logic [31:0] d; int lat; bit tmo;
    txn(1'b0, SZ_HALF, 8'h41, 32'h0000BEEF, d, lat, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL mis_moc: got timeout want moc"); end
`ifdef MEM_MISALIGN_FAULT_EN
    n_cmp++; if (bus.Fault !== 1'b1) begin n_bad++; $display("FAIL mis_fault: got %0b want 1", bus.Fault); end
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mis_dout: got %08h want 00000000", d); end
    release_mfa();
    n_cmp++; if (bus.Fault !== 1'b0) begin n_bad++; $display("FAIL mis_fault_clear: got %0b want 0", bus.Fault); end
    txn(1'b1, SZ_HALF, 8'h40, 32'h0, d, lat, tmo); release_mfa();
    n_cmp++; if (tmo || d !== 32'h00007788) begin n_bad++; $display("FAIL mis_mem: got %08h want 00007788", d); end
`else
    n_cmp++; if (bus.Fault !== 1'b0) begin n_bad++; $display("FAIL mis_fault: got %0b want 0", bus.Fault); end
    release_mfa();
    txn(1'b1, SZ_BYTE, 8'h40, 32'h0, d, lat, tmo); release_mfa();
    n_cmp++; if (tmo || d !== 32'h000000BE) begin n_bad++; $display("FAIL mis_mem40: got %08h want 000000be", d); end
    txn(1'b1, SZ_BYTE, 8'h41, 32'h0, d, lat, tmo); release_mfa();
    n_cmp++; if (tmo || d !== 32'h000000EF) begin n_bad++; $display("FAIL mis_mem41: got %08h want 000000ef", d); end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] d; int lat; bit tmo;
    logic [7:0] exp_b [4];
    logic [7:0] wr_addr;
`ifdef MEM_MISALIGN_FAULT_EN
    wr_addr = 8'hFC;  // 0xFF would fault in this build
`else
    wr_addr = 8'hFF;
`endif
    exp_b[0] = 8'hCA; exp_b[1] = 8'hFE; exp_b[2] = 8'hF0; exp_b[3] = 8'h0D;
    txn(1'b0, SZ_WORD, wr_addr, 32'hCAFEF00D, d, lat, tmo); release_mfa();
    txn(1'b1, SZ_WORD, 8'hFC, 32'h0, d, lat, tmo); release_mfa();
    n_cmp++; if (tmo || d !== 32'hCAFEF00D) begin n_bad++; $display("FAIL wrap_word: got %08h want cafef00d", d); end
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, SZ_BYTE, 8'hFC + 8'(i), 32'h0, d, lat, tmo); release_mfa();
      n_cmp++;
      if (tmo || d !== {24'd0, exp_b[i]}) begin
        n_bad++; $display("FAIL wrap_byte[%0d]: got %08h want %08h", i, d, {24'd0, exp_b[i]});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.MFA = 1'b0; bus.RW = 1'b0; bus.DataSize = SZ_BYTE; bus.Address = '0; bus.DataIn = '0;
    repeat (3) @(posedge Clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge Clk); #1;
    test_word_rw();
    test_strb();
    test_hold();
    test_abort();
    test_reset_mid();
    test_misalign();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
